// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver feeding a one-byte holding register on a ready/valid
// byte stream, with one-cycle overrun and framing-error pulses.
module uart_rx #(
  parameter int unsigned CLOCK_HZ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned BIT_CYCLES = CLOCK_HZ / BAUD;
  localparam int unsigned HALF       = BIT_CYCLES / 2;
  localparam int unsigned CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [1:0]    r_sync;
  logic [1:0]    r_primed;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_stop_ok;
  logic          r_stop_bad;
  logic          r_valid;
  logic [7:0]    r_data;
  logic          r_ferr;
  logic          r_ovr;
  logic          r_busy;

  logic          w_s;
  logic          w_cnt_zero;
  logic          w_active;
  logic          w_xfer;
  logic          w_accept;

  // The synchronizer resets to 1, so the line is not trusted until both flops
  // have reloaded from the pin; otherwise a line held low across reset would
  // look like a fresh high-to-low start edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync   <= 2'b11;
      r_primed <= '0;
    end else begin
      r_sync   <= {r_sync[0], serial_in};
      r_primed <= {r_primed[0], 1'b1};
    end
  end

  assign w_s        = r_sync[1];
  assign w_cnt_zero = (r_cnt == '0);
  assign w_active   = (r_state == START) || (r_state == DATA) || (r_state == STOP);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= WAIT_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_stop_ok  <= 1'b0;
      r_stop_bad <= 1'b0;
    end else begin
      r_stop_ok  <= 1'b0;
      r_stop_bad <= 1'b0;
      case (r_state)
        WAIT_IDLE: begin
          if (w_s && r_primed[1]) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (!w_s) begin
            r_cnt   <= HALF_LOAD;
            r_state <= START;
          end
        end
        START: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (!w_s) begin
            r_cnt   <= BIT_LOAD;
            r_idx   <= '0;
            r_state <= DATA;
          end else begin
            r_state <= IDLE;
          end
        end
        DATA: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_shift <= {w_s, r_shift[7:1]};
            r_cnt   <= BIT_LOAD;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (w_s) begin
            r_stop_ok <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_stop_bad <= 1'b1;
            r_state    <= WAIT_IDLE;
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign w_xfer   = r_valid && rx_ready;
  assign w_accept = !r_valid || rx_ready;

  // All visible outputs are registered one edge after the stop-bit decision;
  // the shift register is untouched in IDLE, so it still holds the byte here.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ferr <= r_stop_bad;
      r_ovr  <= r_stop_ok && !w_accept;
      r_busy <= w_active;
      if (r_stop_ok && w_accept) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_valid      = r_valid;
  assign rx_data       = r_data;
  assign framing_error = r_ferr;
  assign overrun       = r_ovr;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are scheduled into an expectation queue
// from the line timing rules; a negedge monitor resolves them against the outputs.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD_R = 100_000;
  localparam int B   = CLK_HZ / BAUD_R;
  localparam int H   = B / 2;
  localparam int LAT = 3 + H + 9 * B;

  typedef enum int {EV_OK, EV_FERR, EV_GLITCH, EV_ABORT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    int         t0;
    int         done;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLOCK_HZ(CLK_HZ),
    .BAUD    (BAUD_R)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (serial_in),
    .rx_ready     (rx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .framing_error(framing_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int n_edge = 0;
  always @(posedge clock) n_edge <= n_edge + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, exp, n_edge);
    end
  endtask

  // Reference model state: what the outputs must show after the most recent edge.
  frame_t     exp_q[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;
  int         n_xfers = 0;
  int         n_ovr_seen = 0;
  int         n_ferr_seen = 0;
  int         last_rise = -1;
  logic       prev_valid = 1'b0;

  initial begin : monitor
    frame_t f;
    logic   exp_busy;
    logic   arrive;
    forever begin
      @(negedge clock);
      exp_busy = 1'b0;
      if (exp_q.size() > 0) begin
        exp_busy = (n_edge > exp_q[0].t0) && (n_edge < exp_q[0].done);
      end
      chk("rx_valid", rx_valid, m_valid);
      chk("rx_data", rx_data, m_data);
      chk("framing_error", framing_error, m_ferr);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, exp_busy);
      if (rx_valid === 1'b1 && rx_ready) n_xfers++;
      if (overrun === 1'b1) n_ovr_seen++;
      if (framing_error === 1'b1) n_ferr_seen++;
      if (rx_valid === 1'b1 && !prev_valid) last_rise = n_edge;
      prev_valid = (rx_valid === 1'b1);

      // Predict the outputs after the coming edge.
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (!reset) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        exp_q.delete();
      end else begin
        arrive = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].done == n_edge + 1) begin
          f = exp_q.pop_front();
          if (f.kind == EV_OK) arrive = 1'b1;
          if (f.kind == EV_FERR) m_ferr = 1'b1;
        end
        if (arrive && (!m_valid || rx_ready)) begin
          m_valid = 1'b1;
          m_data  = f.data;
        end else if (arrive) begin
          m_ovr = 1'b1;
        end else if (m_valid && rx_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic idle_bits(input int n);
    serial_in = 1'b1;
    repeat (n * B) begin
      @(posedge clock);
      #1;
    end
  endtask

  // mode 0: plain frame; 1: pulse rx_ready for exactly the delivery edge;
  // 2: reset asserted and released inside data bit 4.
  task automatic send_frame(input logic [7:0] data, input logic stop_val,
                            input int extra_low, input int mode, output int c);
    frame_t     f;
    logic [9:0] bits;
    int         done;
    @(posedge clock);
    #1;
    c    = n_edge;
    done = c + 1 + LAT;
    bits = {stop_val, data, 1'b0};
    f.kind = (mode == 2) ? EV_ABORT : (stop_val ? EV_OK : EV_FERR);
    f.data = data;
    f.t0   = c + 3;
    f.done = (mode == 2) ? 32'h7fff_ffff : done;
    exp_q.push_back(f);
    for (int j = 0; j < (10 + extra_low) * B; j++) begin
      if (j > 0) begin
        @(posedge clock);
        #1;
      end
      serial_in = (j < 10 * B) ? bits[j / B] : 1'b0;
      if (mode == 1) rx_ready = (n_edge == done - 1);
      if (mode == 2 && j == 5 * B + 2) reset = 1'b0;
      if (mode == 2 && j == 5 * B + 6) reset = 1'b1;
    end
  endtask

  task automatic send_glitch(input int len);
    frame_t f;
    @(posedge clock);
    #1;
    f.kind = EV_GLITCH;
    f.data = 8'h00;
    f.t0   = n_edge + 3;
    f.done = n_edge + 3 + H + 1;
    exp_q.push_back(f);
    serial_in = 1'b0;
    repeat (len) begin
      @(posedge clock);
      #1;
    end
    serial_in = 1'b1;
  endtask

  task automatic drain();
    @(posedge clock);
    #1 rx_ready = 1'b1;
    @(posedge clock);
    #1 rx_ready = 1'b0;
  endtask

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

  bit rand_ready_on;

  initial begin : main
    int c;
    int x0, o0, f0;
    logic [7:0] rb;

    // Reset hold with the line idle, then a single frame and its latency.
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    idle_bits(2);
    send_frame(8'h55, 1'b1, 0, 0, c);
    chk("latency_55", last_rise - (c + 1), LAT);
    chk("data_55", rx_data, 8'h55);
    @(posedge clock);
    #1 rx_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("valid_drop_55", rx_valid, 1'b0);
    chk("data_kept_55", rx_data, 8'h55);

    // Back-to-back frames with the consumer always ready.
    x0 = n_xfers; o0 = n_ovr_seen; f0 = n_ferr_seen;
    send_frame(8'hA5, 1'b1, 0, 0, c);
    send_frame(8'h00, 1'b1, 0, 0, c);
    send_frame(8'hFF, 1'b1, 0, 0, c);
    idle_bits(1);
    chk("b2b_xfers", n_xfers - x0, 3);
    chk("b2b_ovr", n_ovr_seen - o0, 0);
    chk("b2b_ferr", n_ferr_seen - f0, 0);

    // Overrun: second byte lost, first byte kept.
    rx_ready = 1'b0;
    o0 = n_ovr_seen;
    send_frame(8'h12, 1'b1, 0, 0, c);
    send_frame(8'h34, 1'b1, 0, 0, c);
    idle_bits(1);
    chk("ovr_pulses", n_ovr_seen - o0, 1);
    chk("ovr_data", rx_data, 8'h12);
    drain();
    chk("ovr_drained", rx_valid, 1'b0);

    // Consumption in the delivery cycle replaces the byte without overrun.
    o0 = n_ovr_seen;
    send_frame(8'h12, 1'b1, 0, 0, c);
    send_frame(8'h34, 1'b1, 0, 1, c);
    idle_bits(1);
    chk("sim_ovr", n_ovr_seen - o0, 0);
    chk("sim_valid", rx_valid, 1'b1);
    chk("sim_data", rx_data, 8'h34);
    drain();

    // Framing error with the line low for two bit times, then recovery.
    f0 = n_ferr_seen;
    send_frame(8'h3C, 1'b0, 1, 0, c);
    idle_bits(3);
    send_frame(8'hC3, 1'b1, 0, 0, c);
    idle_bits(1);
    chk("ferr_pulses", n_ferr_seen - f0, 1);
    chk("ferr_next_data", rx_data, 8'hC3);
    drain();

    // Short low glitch produces nothing.
    x0 = n_xfers;
    send_glitch(H / 2);
    idle_bits(2);
    chk("glitch_busy", busy, 1'b0);
    chk("glitch_valid", rx_valid, 1'b0);

    // Reset mid-frame with a byte held; the line stays low across release.
    rb = 8'($urandom);
    send_frame(rb, 1'b1, 0, 0, c);
    chk("pre_reset_valid", rx_valid, 1'b1);
    rb = {3'b111, 1'b0, 4'($urandom)};
    send_frame(rb, 1'b1, 0, 2, c);
    idle_bits(2);
    chk("post_reset_valid", rx_valid, 1'b0);
    chk("post_reset_data", rx_data, 8'h00);
    send_frame(8'h81, 1'b1, 0, 0, c);
    idle_bits(1);
    chk("after_reset_data", rx_data, 8'h81);
    drain();

    // Random bytes, gaps and a sparse consumer.
    rand_ready_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          rb = 8'($urandom);
          send_frame(rb, 1'b1, 0, 0, c);
          if ($urandom_range(0, 2) != 0) idle_bits(int'($urandom_range(1, 2)));
        end
        rand_ready_on = 1'b0;
      end
      begin
        while (rand_ready_on) begin
          @(posedge clock);
          #1 rx_ready = ($urandom_range(0, 99) < 3);
        end
      end
    join
    rx_ready = 1'b0;
    idle_bits(2);
    drain();
    idle_bits(1);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_valid", rx_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
